// File: rtl/bram_add_pkg.sv
// Shared types and the operand adder for the bram_add_seq sequencer.
// Build option BRAM_ADD_SAT_EN: sums saturate to all-ones instead of wrapping.
package bram_add_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  // Widest operand the adder function handles; callers zero-extend into it.
  localparam int ADD_MAX_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    FIN
  } state_t;

  typedef struct packed {
    logic                 carry;
    logic [ADD_MAX_W-1:0] sum;
  } add_res_t;

  // Adds two width-bit unsigned operands held in ADD_MAX_W-bit containers.
  // width must be below ADD_MAX_W so the carry has a bit to land in.
  function automatic add_res_t add_op(input logic [ADD_MAX_W-1:0] a,
                                      input logic [ADD_MAX_W-1:0] b,
                                      input int unsigned          width);
    logic [ADD_MAX_W:0]   full;
    logic [ADD_MAX_W-1:0] mask;
    add_res_t             res;
    full      = {1'b0, a} + {1'b0, b};
    mask      = ~({ADD_MAX_W{1'b1}} << width);
    res.carry = |(full >> width);
    res.sum   = full[ADD_MAX_W-1:0] & mask;
`ifdef BRAM_ADD_SAT_EN
    if (res.carry) res.sum = mask;
`else
    res.sum   = res.sum;
`endif
    return res;
  endfunction

endpackage

// File: rtl/bram_add_seq_if.sv
// Controller handshake plus source/result block-RAM ports of bram_add_seq.
// slave = the sequencer; master = controller and RAMs around it.
interface bram_add_seq_if import bram_add_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              ovf;

  logic              ena_src;
  logic              wea_src;
  logic [ADDR_W-1:0] addr_src;
  logic [DATA_W-1:0] dout_a;
  logic [DATA_W-1:0] dout_b;

  logic              ena_dst;
  logic              wea_dst;
  logic [ADDR_W-1:0] addr_dst;
  logic [DATA_W-1:0] din_dst;

  modport slave (
    input  start, base_addr, len, dout_a, dout_b,
    output busy, done, ovf,
    output ena_src, wea_src, addr_src,
    output ena_dst, wea_dst, addr_dst, din_dst
  );

  modport master (
    output start, base_addr, len, dout_a, dout_b,
    input  busy, done, ovf,
    input  ena_src, wea_src, addr_src,
    input  ena_dst, wea_dst, addr_dst, din_dst
  );

endinterface

// File: rtl/bram_add_alu.sv
// Registered operand adder: captures a+b on cap and keeps a sticky carry flag.
// Wrap or saturate behaviour follows BRAM_ADD_SAT_EN through bram_add_pkg::add_op.
module bram_add_alu import bram_add_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cap,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  add_res_t res;
  logic     unused_hi;

  always_comb res = add_op(ADD_MAX_W'(a), ADD_MAX_W'(b), DATA_W);

  // Upper container bits are always zero for DATA_W-bit operands.
  assign unused_hi = ^res.sum[ADD_MAX_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (cap) begin
      sum <= res.sum[DATA_W-1:0];
      ovf <= ovf | res.carry;
    end else if (clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_add_seq.sv
// Walks an address range, adds source RAM A and B words and writes the sum to the result RAM.
// Build option BRAM_ADD_SAT_EN (in bram_add_pkg) selects saturating sums; timing is unchanged.
module bram_add_seq import bram_add_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input logic            clk,
  input logic            rst_n,
  bram_add_seq_if.slave  bus
);

  localparam int WCNT_W = $clog2(RD_LAT + 1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cur, cur_nx;
  logic [ADDR_W:0]     rem, rem_nx;
  logic [WCNT_W-1:0]   wcnt, wcnt_nx;
  logic                accept;
  logic                capture;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_nx = state;
    cur_nx   = cur;
    rem_nx   = rem;
    wcnt_nx  = wcnt;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          cur_nx   = bus.base_addr;
          rem_nx   = bus.len;
          state_nx = (bus.len == '0) ? FIN : RD;
        end
      end
      RD: begin
        wcnt_nx  = WCNT_W'(RD_LAT);
        state_nx = WAIT;
      end
      WAIT: begin
        wcnt_nx = wcnt - WCNT_W'(1);
        if (wcnt == WCNT_W'(1)) begin
          capture  = 1'b1;
          state_nx = WR;
        end
      end
      WR: begin
        cur_nx   = cur + ADDR_W'(1);
        rem_nx   = rem - (ADDR_W + 1)'(1);
        state_nx = (rem == (ADDR_W + 1)'(1)) ? FIN : RD;
      end
      FIN: begin
        // An empty run enters FIN straight from IDLE, before done could be
        // registered; FIN holds until the done pulse has actually been shown.
        state_nx = bus.done ? IDLE : FIN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so each one lines up
  // with the state it belongs to, without a combinational path to the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur          <= '0;
      rem          <= '0;
      wcnt         <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.ena_src  <= 1'b0;
      bus.addr_src <= '0;
      bus.ena_dst  <= 1'b0;
      bus.wea_dst  <= 1'b0;
      bus.addr_dst <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_nx;
      cur         <= cur_nx;
      rem         <= rem_nx;
      wcnt        <= wcnt_nx;
      bus.busy    <= (state_nx == RD) || (state_nx == WAIT) || (state_nx == WR);
      bus.done    <= (state_nx == FIN) && (state != IDLE);
      bus.ena_src <= (state_nx == RD);
      bus.ena_dst <= (state_nx == WR);
      bus.wea_dst <= (state_nx == WR);
      if (state_nx == RD) bus.addr_src <= cur_nx;
      if (capture)        bus.addr_dst <= cur;
    end
  end

  assign bus.wea_src = 1'b0;

  bram_add_alu #(.DATA_W(DATA_W)) u_alu (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .cap   (capture),
    .a     (bus.dout_a),
    .b     (bus.dout_b),
    .sum   (bus.din_dst),
    .ovf   (bus.ovf)
  );

endmodule

// File: doc/bram_add_seq.md
Name: bram_add_seq

Overview:
- Sequencer that sits directly downstream of the two source block-RAM wrappers (8-bit address, 16-bit data, 1-cycle read latency) and upstream of a result block-RAM.
- On a start pulse it walks an address range, reads operand A and operand B at the same address, adds them, and writes the sum to the result RAM at that address.
- Start/busy/done handshake to the top-level controller; sticky overflow flag.

Parameters:
- ADDR_W, 8, address width of all three RAMs.
- DATA_W, 16, data width of operands and sum.
- RD_LAT, 1, source RAM read latency in cycles (>=1).

Ports:
- clk  in  1  single clock; all RAM ports share it.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first address; sampled with start.
- len  in  ADDR_W+1  element count 0..2^ADDR_W; sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the run completes.
- ovf  out  1  sticky: any sum carried out of DATA_W; cleared on accepted start.
- ena_src  out  1  read enable driven to both source RAMs.
- wea_src  out  1  constant 0; source RAMs are read-only here.
- addr_src  out  ADDR_W  read address driven to both source RAMs.
- dout_a  in  DATA_W  operand A read data.
- dout_b  in  DATA_W  operand B read data.
- ena_dst  out  1  result RAM enable.
- wea_dst  out  1  result RAM write enable.
- addr_dst  out  ADDR_W  result RAM address.
- din_dst  out  DATA_W  sum written to result RAM.

Behaviour:
- All outputs are registered.
- Reset, asynchronous: state=IDLE; busy, done, ovf, ena_src, ena_dst, wea_dst = 0; addr_src, addr_dst, din_dst = 0; counters = 0.
- Reset asserted mid-run aborts the run immediately. No further RAM enables are driven. Partial results already written remain in the result RAM.
- State IDLE:
  - On start=1, latch base_addr into cur and len into rem; clear ovf.
  - If len==0, go to FIN. Otherwise go to RD.
- State RD (1 cycle): ena_src=1, addr_src=cur. Go to WAIT with wcnt=RD_LAT.
- State WAIT (RD_LAT cycles): ena_src=0.
  - Decrement wcnt each cycle.
  - In the cycle where wcnt==1, dout_a/dout_b are valid. On that edge:
    - din_dst <= (a+b) truncated to DATA_W.
    - ovf <= ovf | carry.
    - addr_dst <= cur.
  - Then go to WR.
- State WR (1 cycle): ena_dst=1, wea_dst=1.
  - cur <= cur+1, wrapping modulo 2^ADDR_W (0xFF -> 0x00).
  - rem <= rem-1.
  - If rem==1, go to FIN; else go to RD.
- State FIN (1 cycle): done=1, busy=0. Go to IDLE.
- Throughput: one element every 2+RD_LAT cycles (3 at default).
- A run of N>0 elements takes N*(2+RD_LAT)+1 cycles from start to done. A len=0 run gives done 2 cycles after start.
- busy is high in RD/WAIT/WR.
- start while not in IDLE is ignored; no queuing.
- start in the same cycle as done (state FIN) is ignored. The controller re-issues start in IDLE.
- Addition is unsigned.
- wea_dst is never high without ena_dst. ena_src and ena_dst are never high in the same cycle.

Optional Feature:
- Macro BRAM_ADD_SAT_EN.
- Defined: sum saturates to all-ones (0xFFFF) on carry-out; ovf is still set.
- Undefined: sum wraps modulo 2^DATA_W; ovf is set on carry.
- Only the din_dst value differs. Timing is identical in both builds.

Decomposition:
- Package bram_add_pkg holds:
  - state enum typedef (IDLE, RD, WAIT, WR, FIN);
  - localparams for the default ADDR_W/DATA_W;
  - the saturating/wrapping add function, selected by the macro.
- One sub-module is natural: bram_add_alu, a registered adder with carry/saturation and a capture enable. The FSM and counters stay in bram_add_seq.

Test Plan:
- Basic run: base_addr=0x00, len=4; A=[1,2,3,0x7FFF]; B=[10,20,30,1]. Result RAM [0..3] = [11,22,33,0x8000]; ovf=0; done 13 cycles after start.
- Overflow: A[5]=0xFFFF, B[5]=0x0002, base=5, len=1. Without macro: result 0x0001. With BRAM_ADD_SAT_EN: result 0xFFFF. ovf=1 in both builds.
- Wrap-around: base=0xFE, len=4. Writes land at 0xFE, 0xFF, 0x00, 0x01; no write to 0x02.
- Edge lengths: len=0 gives a done pulse 2 cycles after start and no ena_src/ena_dst activity. len=256 from base 0 writes all 256 locations.
- Handshake: start re-pulsed while busy is ignored and the address sequence is unchanged. start after done begins a new run and clears ovf.
- Reset mid-run: deassert rst_n during the 3rd element's WAIT. All outputs are 0 asynchronously and there is no further write. After release, a new start runs normally.
